uart_tx_serializer: RTL and testbench

//  Parametrised UART transmit serializer; successor to the fixed 8-bit shifter.

---
 rtl/uart_tx_serializer.sv | 155 +++++++++++++++
 tb/tb_uart_tx_serializer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: valid/ready word in, start/data/[parity]/stop frame out on tx.
// Optional parity bit enabled by defining UART_TX_PARITY_EN.
module uart_tx_serializer #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter int MSB_FIRST    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_CNT = BW'(DATA_W);
  localparam logic [BW-1:0] STOP_CNT = BW'(STOP_BITS);

  if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
    $error("uart_tx_serializer: DATA_W must be 5..9");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_clks
    $error("uart_tx_serializer: CLKS_PER_BIT must be >= 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
  end
  if (MSB_FIRST != 0 && MSB_FIRST != 1) begin : g_bad_msb
    $error("uart_tx_serializer: MSB_FIRST must be 0 or 1");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_par
    $error("uart_tx_serializer: PARITY_ODD must be 0 or 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t            state_q;
  logic [CW-1:0]     clk_cnt_q;
  logic [BW-1:0]     bit_cnt_q;
  logic [DATA_W-1:0] sh_q;
  logic              tx_q;
  logic              done_q;
`ifdef UART_TX_PARITY_EN
  logic              par_q;
`endif

  // Outgoing bit always sits at one end of sh_q; direction fixed at elaboration.
  logic              cur_bit;
  logic [DATA_W-1:0] sh_next;
  if (MSB_FIRST != 0) begin : g_msb
    assign cur_bit = sh_q[DATA_W-1];
    assign sh_next = {sh_q[DATA_W-2:0], 1'b0};
  end else begin : g_lsb
    assign cur_bit = sh_q[0];
    assign sh_next = {1'b0, sh_q[DATA_W-1:1]};
  end

  wire bit_end = (clk_cnt_q == CNT_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      sh_q      <= '0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (state_q == S_IDLE) begin
        tx_q <= 1'b1;
        if (in_valid) begin
          sh_q      <= in_data;
          tx_q      <= 1'b0;
          state_q   <= S_START;
          clk_cnt_q <= '0;
          bit_cnt_q <= '0;
`ifdef UART_TX_PARITY_EN
          par_q     <= (^in_data) ^ PARITY_ODD[0];
`endif
        end
      end else if (!bit_end) begin
        clk_cnt_q <= clk_cnt_q + CW'(1);
      end else begin
        clk_cnt_q <= '0;
        case (state_q)
          S_START: begin
            state_q   <= S_DATA;
            tx_q      <= cur_bit;
            sh_q      <= sh_next;
            bit_cnt_q <= BW'(1);
          end
          S_DATA: begin
            if (bit_cnt_q == DATA_CNT) begin
`ifdef UART_TX_PARITY_EN
              state_q   <= S_PARITY;
              tx_q      <= par_q;
`else
              state_q   <= S_STOP;
              tx_q      <= 1'b1;
              bit_cnt_q <= BW'(1);
`endif
            end else begin
              tx_q      <= cur_bit;
              sh_q      <= sh_next;
              bit_cnt_q <= bit_cnt_q + BW'(1);
            end
          end
`ifdef UART_TX_PARITY_EN
          S_PARITY: begin
            state_q   <= S_STOP;
            tx_q      <= 1'b1;
            bit_cnt_q <= BW'(1);
          end
`endif
          S_STOP: begin
            if (bit_cnt_q == STOP_CNT) begin
              state_q   <= S_IDLE;
              tx_q      <= 1'b1;
              done_q    <= 1'b1;
              bit_cnt_q <= '0;
            end else begin
              bit_cnt_q <= bit_cnt_q + BW'(1);
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign in_ready = (state_q == S_IDLE) & ~reset;
  assign busy     = (state_q != S_IDLE);
  assign tx       = tx_q;
  assign done     = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: four instances (LSB/MSB first, 2 stop bits, odd parity)
// driven from a vector table, a mid-frame reset sequence and random words vs a frame model.
module tb_uart_tx_serializer;

  localparam int C = 4;
  localparam int MSB [4] = '{0, 1, 0, 0};
  localparam int STOP[4] = '{1, 1, 2, 1};
  localparam int ODD [4] = '{0, 0, 0, 1};

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] vld, rdy, txo, bsy, dn;
  logic [7:0] din [4];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    uart_tx_serializer #(
      .DATA_W(8), .CLKS_PER_BIT(C), .STOP_BITS(STOP[g]),
      .MSB_FIRST(MSB[g]), .PARITY_ODD(ODD[g])
    ) u_dut (
      .clk(clk), .reset(rst), .in_valid(vld[g]), .in_ready(rdy[g]),
      .in_data(din[g]), .tx(txo[g]), .busy(bsy[g]), .done(dn[g])
    );
  end

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got {tx,busy,done,ready}=%b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] obs(input int k);
    return {txo[k], bsy[k], dn[k], rdy[k]};
  endfunction

  // Expected line sequence, one character per UART bit, built straight from the frame rules.
  function automatic string model(input int k, input logic [7:0] d);
    string s = "0";
    for (int i = 0; i < 8; i++) begin
      if ((MSB[k] != 0) ? d[7-i] : d[i]) s = {s, "1"}; else s = {s, "0"};
    end
`ifdef UART_TX_PARITY_EN
    if ((^d) != (ODD[k] != 0)) s = {s, "1"}; else s = {s, "0"};
`endif
    for (int i = 0; i < STOP[k]; i++) s = {s, "1"};
    return s;
  endfunction

  // Called just after a negedge. Returns at the negedge of the done cycle.
  task automatic send(input int k, input logic [7:0] d, input bit hold, input string exp);
    int nb = exp.len();
    logic eb;
    chk($sformatf("ready_before_%0d", k), {3'b0, rdy[k]}, 4'b0001);
    din[k] = d;
    vld[k] = 1'b1;
    @(posedge clk);
    for (int c = 0; c < nb * C; c++) begin
      @(negedge clk);
      if (!hold) vld[k] = 1'b0;
      din[k] = 8'($urandom);
      eb = (exp[c / C] == "1");
      chk($sformatf("frame_i%0d_d%02h_c%0d", k, d, c), obs(k), {eb, 3'b100});
    end
    @(negedge clk);
    chk($sformatf("done_i%0d_d%02h", k, d), obs(k), 4'b1011);
  endtask

  task automatic idle_chk(input int k);
    @(negedge clk);
    chk($sformatf("idle_after_i%0d", k), obs(k), 4'b1001);
  endtask

  typedef struct {
    int         k;
    logic [7:0] d;
    bit         hold;
    string      seq;
  } vec_t;

  function automatic vec_t mk(input int k, input logic [7:0] d, input bit hold, input string seq);
    vec_t v;
    v.k = k; v.d = d; v.hold = hold; v.seq = seq;
    return v;
  endfunction

  initial begin
    vec_t tbl[$];
    int   k, n;
    bit   hold;
    logic [7:0] d;

`ifdef UART_TX_PARITY_EN
    tbl.push_back(mk(0, 8'h0F, 1'b0, "01111000001"));
    tbl.push_back(mk(1, 8'h0F, 1'b0, "00000111101"));
    tbl.push_back(mk(2, 8'h55, 1'b1, "010101010011"));
    tbl.push_back(mk(2, 8'h33, 1'b0, "011001100011"));
    tbl.push_back(mk(0, 8'h07, 1'b0, "01110000011"));
    tbl.push_back(mk(3, 8'h07, 1'b0, "01110000001"));
`else
    tbl.push_back(mk(0, 8'h0F, 1'b0, "0111100001"));
    tbl.push_back(mk(1, 8'h0F, 1'b0, "0000011111"));
    tbl.push_back(mk(2, 8'h55, 1'b1, "01010101011"));
    tbl.push_back(mk(2, 8'h33, 1'b0, "01100110011"));
    tbl.push_back(mk(0, 8'h07, 1'b0, "0111000001"));
    tbl.push_back(mk(3, 8'h07, 1'b0, "0111000001"));
`endif

    rst = 1'b1;
    vld = 4'hF;
    for (int i = 0; i < 4; i++) din[i] = 8'hA5;
    repeat (3) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) chk($sformatf("in_reset_i%0d", i), obs(i), 4'b1000);
    end
    rst = 1'b0;
    vld = 4'h0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) chk($sformatf("after_reset_i%0d", i), obs(i), 4'b1001);

    foreach (tbl[i]) begin
      send(tbl[i].k, tbl[i].d, tbl[i].hold, tbl[i].seq);
      if (!tbl[i].hold) idle_chk(tbl[i].k);
    end

    // Reset during data bit 3 of 0xA5: abort, no done, then a clean frame.
    din[0] = 8'hA5;
    vld[0] = 1'b1;
    @(posedge clk);
    for (int c = 0; c <= 4 * C + 1; c++) begin
      @(negedge clk);
      vld[0] = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("abort_in_reset", obs(0), 4'b1000);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_released", obs(0), 4'b1001);
    for (int c = 0; c < 12 * C; c++) begin
      @(negedge clk);
      chk("abort_quiet", obs(0), 4'b1001);
    end
    send(0, 8'h3C, 1'b0, model(0, 8'h3C));
    idle_chk(0);

    // Random words; a held frame chains straight into the next one on the same instance.
    k = 0;
    hold = 1'b0;
    n = 24;
    for (int it = 0; it < n; it++) begin
      if (!hold) k = $urandom_range(0, 3);
      d = 8'($urandom);
      hold = (it != n - 1) && ($urandom_range(0, 2) == 0);
      send(k, d, hold, model(k, d));
      if (!hold) idle_chk(k);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
